// File: rtl/proj_to_affine.sv
// Projective (X:Y:Z) to affine (X/Z, Y/Z) over GF(2^255-19): external inverter for Z^-1,
// then two bit-serial modular multiplies. Optional Z==0 detection under P2A_ZERO_CHECK_EN.
module proj_to_affine (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [254:0] x_in,
    input  logic [254:0] y_in,
    input  logic [254:0] z_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [254:0] x_out,
    output logic [254:0] y_out,
    output logic         inv_start,
    output logic [254:0] inv_a,
    input  logic [254:0] inv_result,
    input  logic         inv_valid
);

    localparam int unsigned NBITS = 255;
    localparam int unsigned IW    = 8;
    localparam logic [255:0] P    = 256'({1'b1, 255'b0} - 256'd19);

    typedef enum logic [2:0] {IDLE, INV_REQ, INV_WAIT, MUL_X, MUL_Y, FIN} state_t;

    state_t        state;
    logic [254:0]  xr, yr, zi;
    logic [255:0]  acc;
    logic [IW-1:0] idx;

    logic          abit;
    logic [255:0]  dbl_raw, dbl, sum_raw, step;

    // One double-and-add step of the MSB-first modular multiplier; every value stays < P.
    always_comb begin
        abit    = (state == MUL_Y) ? yr[idx] : xr[idx];
        dbl_raw = acc << 1;
        dbl     = (dbl_raw >= P) ? (dbl_raw - P) : dbl_raw;
        sum_raw = dbl + (abit ? {1'b0, zi} : 256'd0);
        step    = (sum_raw >= P) ? (sum_raw - P) : sum_raw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            inv_start <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            inv_a     <= '0;
            xr        <= '0;
            yr        <= '0;
            zi        <= '0;
            acc       <= '0;
            idx       <= '0;
        end else begin
            inv_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= x_in;
                        yr    <= y_in;
                        inv_a <= z_in;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= INV_REQ;
`ifdef P2A_ZERO_CHECK_EN
                        inv_start <= (z_in != '0);
`else
                        inv_start <= 1'b1;
`endif
                    end
                end
                INV_REQ: begin
`ifdef P2A_ZERO_CHECK_EN
                    // Z==0 has no inverse: skip the inverter and report through err.
                    if (inv_a == '0) begin
                        x_out <= '0;
                        y_out <= '0;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        state <= INV_WAIT;
                    end
`else
                    state <= INV_WAIT;
`endif
                end
                INV_WAIT: begin
                    if (inv_valid) begin
                        zi    <= inv_result;
                        acc   <= '0;
                        idx   <= IW'(NBITS - 1);
                        state <= MUL_X;
                    end
                end
                MUL_X: begin
                    acc <= step;
                    idx <= idx - IW'(1);
                    if (idx == '0) begin
                        x_out <= step[254:0];
                        acc   <= '0;
                        idx   <= IW'(NBITS - 1);
                        state <= MUL_Y;
                    end
                end
                MUL_Y: begin
                    acc <= step;
                    idx <= idx - IW'(1);
                    if (idx == '0) begin
                        y_out <= step[254:0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proj_to_affine.sv
// Bench for proj_to_affine: random-latency inverter model with level-held valid,
// expected results queued at start and compared at done. Zero-Z case under P2A_ZERO_CHECK_EN.
module tb_proj_to_affine;

    localparam logic [255:0] P = 256'({1'b1, 255'b0} - 256'd19);

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [254:0] x_in, y_in, z_in;
    logic         busy, done, err;
    logic [254:0] x_out, y_out;
    logic         inv_start;
    logic [254:0] inv_a;
    logic [254:0] inv_result;
    logic         inv_valid;

    proj_to_affine dut (
        .clk(clk), .rst(rst), .start(start),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy), .done(done), .err(err),
        .x_out(x_out), .y_out(y_out),
        .inv_start(inv_start), .inv_a(inv_a),
        .inv_result(inv_result), .inv_valid(inv_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [254:0] x;
        logic [254:0] y;
        logic         e;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           n_inv_start = 0;
    int           n_done = 0;
    int           valid_cyc = 0;
    logic [254:0] z_seen = '0;
    bit           a_stable = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (inv_start) n_inv_start++;
        if (done) n_done++;
    end

    function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
        logic [511:0] prod;
        logic [511:0] r;
        prod = {257'd0, a} * {257'd0, b};
        r    = prod % {256'd0, P};
        return r[254:0];
    endfunction

    // Fermat inverse z^(p-2), independent of the DUT's datapath.
    function automatic logic [254:0] invmod(input logic [254:0] z);
        logic [255:0] e;
        logic [254:0] r;
        logic [254:0] b;
        e = P - 256'd2;
        r = 255'd1;
        b = z;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mulmod(r, b);
            b = mulmod(b, b);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inverter model: drops valid on start, raises it (and holds it) after 5..600 cycles.
    initial begin
        int lat;
        inv_valid  = 1'b0;
        inv_result = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                inv_valid = 1'b0;
            end else if (inv_start) begin
                inv_valid = 1'b0;
                z_seen    = inv_a;
                a_stable  = 1'b1;
                lat       = int'($urandom_range(5, 600));
                for (int k = 0; k < lat && !rst; k++) begin
                    @(posedge clk); #1;
                    if (inv_a !== z_seen) a_stable = 1'b0;
                end
                if (!rst) begin
                    inv_result = invmod(z_seen);
                    inv_valid  = 1'b1;
                    valid_cyc  = cyc;
                end
            end
        end
    end

    task automatic run(input string tag, input logic [254:0] x, input logic [254:0] y,
                       input logic [254:0] z, input logic [254:0] ex, input logic [254:0] ey,
                       input logic ee, input bit hold, input bit zero);
        int   is0, d0, acc_cyc;
        bit   got;
        exp_t e;
        sb.push_back('{x: ex, y: ey, e: ee});
        is0   = n_inv_start;
        d0    = n_done;
        x_in  = x;
        y_in  = y;
        z_in  = z;
        start = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (!hold) start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 256'(got), 256'd1);
        if (got) begin
            e = sb.pop_front();
            check({tag, "_x"}, 256'(x_out), 256'(e.x));
            check({tag, "_y"}, 256'(y_out), 256'(e.y));
            check({tag, "_err"}, 256'(err), 256'(e.e));
            check({tag, "_busy_at_done"}, 256'(busy), 256'd0);
            if (zero) check({tag, "_latency"}, 256'(cyc - acc_cyc), 256'd1);
            else      check({tag, "_latency"}, 256'(cyc - valid_cyc), 256'd511);
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_inv_starts"}, 256'(n_inv_start - is0), zero ? 256'd0 : 256'd1);
        check({tag, "_dones"}, 256'(n_done - d0), 256'd1);
        if (!zero) begin
            check({tag, "_inv_a"}, 256'(z_seen), 256'(z));
            check({tag, "_inv_a_stable"}, 256'(a_stable), 256'd1);
        end
    endtask

    initial begin
        logic [254:0] pm1, pm3, rx, ry, rz;
        logic [255:0] w;
        bit           seen;
        pm1 = 255'(P - 256'd1);
        pm3 = 255'(P - 256'd3);

        rst   = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        z_in  = '0;
        #1;
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_done", 256'(done), 256'd0);
        check("rst_err", 256'(err), 256'd0);
        check("rst_inv_start", 256'(inv_start), 256'd0);
        check("rst_x_out", 256'(x_out), 256'd0);
        check("rst_y_out", 256'(y_out), 256'd0);
        check("rst_inv_a", 256'(inv_a), 256'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run("t1", 255'd5, 255'd7, 255'd1, 255'd5, 255'd7, 1'b0, 1'b0, 1'b0);
        run("t2a", 255'd2, 255'd4, 255'd2, 255'd1, 255'd2, 1'b0, 1'b0, 1'b0);
        run("t2b", pm1, 255'd0, pm1, 255'd1, 255'd0, 1'b0, 1'b0, 1'b0);
        run("t3", 255'd3, 255'd1, pm1, pm3, pm1, 1'b0, 1'b0, 1'b0);

        // Random point, start held high through the whole operation.
        w  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        rx = 255'(w % P);
        w  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ry = 255'(w % P);
        w  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        rz = 255'(w % (P - 256'd1)) + 255'd1;
        run("t4", rx, ry, rz, mulmod(rx, invmod(rz)), mulmod(ry, invmod(rz)), 1'b0, 1'b1, 1'b0);

        // Reset in the middle of MUL_X.
        x_in  = 255'd5;
        y_in  = 255'd7;
        z_in  = 255'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(posedge clk); #1;
            if (inv_valid) seen = 1'b1;
        end
        check("t5_inv_valid_seen", 256'(seen), 256'd1);
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_busy", 256'(busy), 256'd0);
        check("t5_done", 256'(done), 256'd0);
        check("t5_x_out", 256'(x_out), 256'd0);
        check("t5_y_out", 256'(y_out), 256'd0);
        check("t5_inv_start", 256'(inv_start), 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run("t5_rerun", 255'd5, 255'd7, 255'd1, 255'd5, 255'd7, 1'b0, 1'b0, 1'b0);

`ifdef P2A_ZERO_CHECK_EN
        run("t6_zero", 255'd9, 255'd11, 255'd0, 255'd0, 255'd0, 1'b1, 1'b0, 1'b1);
        run("t6_clear", 255'd5, 255'd7, 255'd1, 255'd5, 255'd7, 1'b0, 1'b0, 1'b0);
`endif

        check("sb_empty", 256'(sb.size()), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
